// File: rtl/writeback_slot_scheduler_if.sv
// rtl/writeback_slot_scheduler_if.sv - request/grant bundle between strand issue logic and the writeback slot scheduler
interface writeback_slot_scheduler_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int IDX_W          = $clog2(NUM_REQUESTERS)
);
    logic [NUM_REQUESTERS-1:0] request;
    logic [NUM_REQUESTERS-1:0] request_long;
    logic                      flush;
    logic [NUM_REQUESTERS-1:0] grant_oh;
    logic                      grant_valid;
    logic [IDX_W-1:0]          grant_idx;

    modport master (
        output request, request_long, flush,
        input  grant_oh, grant_valid, grant_idx
    );

    modport slave (
        input  request, request_long, flush,
        output grant_oh, grant_valid, grant_idx
    );
endinterface

// File: rtl/writeback_slot_scheduler.sv
// rtl/writeback_slot_scheduler.sv - round-robin issue arbiter that keeps issued instructions off the same writeback cycle
// Optional conflict statistics counter built when WB_SCHED_STATS_EN is defined.
module writeback_slot_scheduler #(
    parameter int NUM_REQUESTERS = 4,
    parameter int SHORT_LATENCY  = 1,
    parameter int LONG_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    writeback_slot_scheduler_if.slave req_if,
    output logic [LONG_LATENCY-1:0]   slot_reserved,
    output logic [31:0]               conflict_count
);
    localparam int IDX_W = $clog2(NUM_REQUESTERS);
    // Reservation bit for a grant after the shift: latency-2; latency 1 yields no bit.
    localparam logic [LONG_LATENCY-1:0] LONG_MASK  = LONG_LATENCY'(1) << (LONG_LATENCY - 2);
    localparam logic [LONG_LATENCY-1:0] SHORT_MASK = (LONG_LATENCY'(1) << SHORT_LATENCY) >> 2;

    logic [LONG_LATENCY-1:0]   slot_reserved_q, slot_reserved_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic                      short_free;
    logic [NUM_REQUESTERS-1:0] eligible;
    logic [IDX_W:0]            cand;
    logic [NUM_REQUESTERS-1:0] grant_oh;
    logic                      grant_valid;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_long;

    always_comb begin
        short_free  = ~slot_reserved_q[SHORT_LATENCY-1];
        eligible    = req_if.request & (req_if.request_long | {NUM_REQUESTERS{short_free}});
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        // Scan from farthest to nearest offset so the nearest eligible strand wins.
        if (!req_if.flush) begin
            for (int off = NUM_REQUESTERS - 1; off >= 0; off--) begin
                cand = {1'b0, ptr_q} + (IDX_W + 1)'(off);
                if (cand >= (IDX_W + 1)'(NUM_REQUESTERS)) begin
                    cand = cand - (IDX_W + 1)'(NUM_REQUESTERS);
                end
                if (eligible[cand[IDX_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[IDX_W-1:0];
                end
            end
        end
        grant_oh   = NUM_REQUESTERS'(grant_valid) << grant_idx;
        grant_long = grant_valid & req_if.request_long[grant_idx];

        slot_reserved_d = slot_reserved_q >> 1;
        if (grant_valid) begin
            slot_reserved_d = slot_reserved_d | (grant_long ? LONG_MASK : SHORT_MASK);
        end
        if (req_if.flush) begin
            slot_reserved_d = '0;
        end

        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reserved_q <= '0;
            ptr_q           <= '0;
        end else begin
            slot_reserved_q <= slot_reserved_d;
            ptr_q           <= ptr_d;
        end
    end

    assign req_if.grant_oh    = grant_oh;
    assign req_if.grant_valid = grant_valid;
    assign req_if.grant_idx   = grant_idx;
    assign slot_reserved      = slot_reserved_q;

`ifdef WB_SCHED_STATS_EN
    logic [31:0] conflict_count_q, conflict_count_d;

    always_comb begin
        conflict_count_d = conflict_count_q;
        if ((|req_if.request) && !grant_valid && !req_if.flush && (conflict_count_q != 32'hFFFF_FFFF)) begin
            conflict_count_d = conflict_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_count_q <= '0;
        end else begin
            conflict_count_q <= conflict_count_d;
        end
    end

    assign conflict_count = conflict_count_q;
`else
    assign conflict_count = 32'h0;
`endif
endmodule
